qam_level_demodulator: RTL and testbench

Receive-side counterpart of the digital QAM modulation chain. Slices incoming 3-bit I/Q amplitude levels back to 2-bit symbols and serialises each symbol pair into a bit stream. Self-synchronises a local 3-bit m-sequence checker against that stream and reports lock, bit errors and bit counts. Sits after the level-transfer stage in loopback and BER test setups, on a single system clock with a symbol strobe.

---
 rtl/qam_level_demodulator.sv | 163 ++++++++++++++++
 tb/tb_qam_level_demodulator.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/qam_level_demodulator.sv
// qam_level_demodulator: slices I/Q levels, serialises symbols and checks a 3-bit m-sequence
module qam_level_demodulator #(
  parameter int LOCK_CNT = 7,
  parameter int LOS_ERRS = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [2:0]       Siga,
  input  logic [2:0]       Sigb,
  input  logic             clr_cnt,
  output logic [1:0]       SigI_rx,
  output logic [1:0]       SigQ_rx,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);
  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int EW = (LOS_ERRS > 1) ? $clog2(LOS_ERRS) : 1;
  localparam logic [MW-1:0] MC_LAST = MW'(LOCK_CNT - 1);
  localparam logic [EW-1:0] EC_LAST = EW'(LOS_ERRS - 1);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t          r_state, w_state_nx;
  logic [3:0]      r_hold;
  logic            r_hold_full;
  logic [3:0]      r_sh;
  logic [1:0]      r_sh_cnt;
  logic            r_busy;
  logic            w_load, w_accept, w_drop;
  logic [2:0]      r_hist, w_hist_nx;
  logic [1:0]      r_ld, w_ld_nx;
  logic [MW-1:0]   r_mc, w_mc_nx;
  logic [EW-1:0]   r_ec, w_ec_nx;
  logic            w_pred, w_match, w_cnt_bit, w_cnt_err;
  logic            w_bit_inc, w_err_inc;
  logic            w_unused;
  // the LSB of an odd level carries no symbol information
  assign w_unused  = ^{Siga[0], Sigb[0]};
  // transfer into the shifter when idle or while it emits its last bit
  assign w_load    = r_hold_full & (~r_busy | (r_sh_cnt == 2'd3));
  assign w_accept  = sym_valid & (~r_hold_full | w_load);
  assign w_drop    = sym_valid & r_hold_full & ~w_load;
  assign bit_out   = r_sh[3];
  assign bit_valid = r_busy;
  // d[n] = d[n-1] ^ d[n-3]; r_hist[0] is the newest bit
  assign w_pred    = r_hist[0] ^ r_hist[2];
  assign w_match   = bit_out == w_pred;
  assign w_bit_inc = w_cnt_bit & ~&bit_cnt;
  assign w_err_inc = w_cnt_err & ~&err_cnt;
  // slice accepted symbols into the received-symbol outputs and holding register
  always_ff @(posedge clk) begin
    if (!rst) begin
      SigI_rx     <= '0;
      SigQ_rx     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_accept) begin
        SigI_rx <= Siga[2:1];
        SigQ_rx <= Sigb[2:1];
        r_hold  <= {Siga[2:1], Sigb[2:1]};
      end
      r_hold_full <= w_accept | (r_hold_full & ~w_load);
    end
  end
  // serialise I[1], I[0], Q[1], Q[0] on four consecutive cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sh     <= '0;
      r_sh_cnt <= '0;
      r_busy   <= 1'b0;
    end else if (w_load) begin
      r_sh     <= r_hold;
      r_sh_cnt <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_sh     <= {r_sh[2:0], 1'b0};
      r_sh_cnt <= r_sh_cnt + 2'd1;
      r_busy   <= r_sh_cnt != 2'd3;
    end
  end
  // checker state register and bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SEARCH;
      r_hist  <= '0;
      r_ld    <= '0;
      r_mc    <= '0;
      r_ec    <= '0;
      locked  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hist  <= w_hist_nx;
      r_ld    <= w_ld_nx;
      r_mc    <= w_mc_nx;
      r_ec    <= w_ec_nx;
      locked  <= w_state_nx == LOCKED;
    end
  end
  // checker next state: acquire history, verify predictions, flywheel while locked
  always_comb begin
    w_state_nx = r_state;
    w_hist_nx  = r_hist;
    w_ld_nx    = r_ld;
    w_mc_nx    = r_mc;
    w_ec_nx    = r_ec;
    w_cnt_bit  = 1'b0;
    w_cnt_err  = 1'b0;
    if (bit_valid) begin
      w_hist_nx = {r_hist[1:0], bit_out};
      case (r_state)
        SEARCH: begin
          w_ld_nx = (r_ld == 2'd3) ? r_ld : r_ld + 2'd1;
          if (r_ld >= 2'd2 && |w_hist_nx) begin
            w_state_nx = TRACK;
            w_mc_nx    = '0;
          end
        end
        TRACK: begin
          if (!w_match) begin
            w_state_nx = SEARCH;
            w_ld_nx    = '0;
          end else if (r_mc == MC_LAST) begin
            w_state_nx = LOCKED;
            w_ec_nx    = '0;
          end else begin
            w_mc_nx = r_mc + 1'b1;
          end
        end
        LOCKED: begin
          w_hist_nx = {r_hist[1:0], w_pred};
          w_cnt_bit = 1'b1;
          w_cnt_err = ~w_match;
          w_ec_nx   = w_match ? '0 : r_ec + 1'b1;
          if (!w_match && r_ec == EC_LAST) begin
            w_state_nx = SEARCH;
            w_ld_nx    = '0;
          end
        end
        default: w_state_nx = SEARCH;
      endcase
    end
  end
  // saturating counters, error pulse and sticky overrun; clear beats increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt  <= '0;
      bit_cnt  <= '0;
      err_flag <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      err_flag <= w_cnt_err;
      err_cnt  <= clr_cnt ? '0 : err_cnt + CNT_W'(w_err_inc);
      bit_cnt  <= clr_cnt ? '0 : bit_cnt + CNT_W'(w_bit_inc);
      overrun  <= clr_cnt ? 1'b0 : (overrun | w_drop);
    end
  end
endmodule

// File: tb/tb_qam_level_demodulator.sv
// tb_qam_level_demodulator: directed scoreboard bench for the QAM level demodulator
module tb_qam_level_demodulator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sym_valid = 1'b0;
  logic [2:0]  Siga = '0;
  logic [2:0]  Sigb = '0;
  logic        clr_cnt = 1'b0;
  logic [1:0]  SigI_rx, SigQ_rx;
  logic        bit_out, bit_valid, locked, err_flag, overrun;
  logic [15:0] err_cnt, bit_cnt;
  int          total = 0;
  int          bad = 0;
  int          n_pulse = 0;
  int          mi = 0;
  bit          q[$];
  bit          mseq[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  qam_level_demodulator dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .Siga(Siga), .Sigb(Sigb),
    .clr_cnt(clr_cnt), .SigI_rx(SigI_rx), .SigQ_rx(SigQ_rx), .bit_out(bit_out),
    .bit_valid(bit_valid), .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt),
    .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every emitted bit must match the oldest expected bit
  always @(negedge clk) begin
    if (rst === 1'b1 && bit_valid !== 1'b0) begin
      if (q.size() == 0) chk("extra_bit", 32'(bit_valid), 32'd0);
      else chk("bit_out", 32'(bit_out), 32'(q.pop_front()));
    end
    if (rst === 1'b1 && err_flag === 1'b1) n_pulse++;
  end

  // drive one strobe for one cycle; bits b[3..0] go out MSB first
  task automatic sym_bits(input bit [3:0] b, input bit push);
    Siga = {b[3], b[2], 1'b1};
    Sigb = {b[1], b[0], 1'b1};
    sym_valid = 1'b1;
    if (push) begin
      q.push_back(b[3]); q.push_back(b[2]); q.push_back(b[1]); q.push_back(b[0]);
    end
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic mseq_sym(input bit [3:0] flip, input bit space);
    bit [3:0] b;
    for (int i = 3; i >= 0; i--) begin
      b[i] = mseq[mi % 7];
      mi++;
    end
    sym_bits(b ^ flip, 1'b1);
    if (space) repeat (3) @(negedge clk);
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sig"}, {SigI_rx, SigQ_rx, bit_out, bit_valid, locked, err_flag, overrun}, 32'd0);
    chk({tag, "_cnt"}, {err_cnt, bit_cnt}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    repeat (10) @(negedge clk);
    chk("idle_valid", 32'(bit_valid), 32'd0);
    // single symbol: levels 5 and 3 slice to 10 and 01
    Siga = 3'd5; Sigb = 3'd3; sym_valid = 1'b1;
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b0); q.push_back(1'b1);
    @(negedge clk);
    sym_valid = 1'b0;
    chk("sigi_rx", 32'(SigI_rx), 32'd2);
    chk("sigq_rx", 32'(SigQ_rx), 32'd1);
    chk("lat_t1", 32'(bit_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat_on", 32'(bit_valid), 32'd1);
    end
    @(negedge clk);
    chk("lat_off", 32'(bit_valid), 32'd0);
    drain();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // continuous m-sequence: lock after 3 + 7 bits, 14 of 24 bits counted
    for (int s = 0; s < 6; s++) mseq_sym(4'b0000, 1'b1);
    drain();
    chk("lock1", 32'(locked), 32'd1);
    chk("err0", 32'(err_cnt), 32'd0);
    chk("bits14", 32'(bit_cnt), 32'd14);
    chk("no_ovr", 32'(overrun), 32'd0);
    // one inverted bit while locked
    mseq_sym(4'b0100, 1'b1);
    mseq_sym(4'b0000, 1'b1);
    drain();
    chk("err1", 32'(err_cnt), 32'd1);
    chk("pulse1", 32'(n_pulse), 32'd1);
    chk("lock_held", 32'(locked), 32'd1);
    chk("bits22", 32'(bit_cnt), 32'd22);
    // three consecutive inverted bits drop lock
    mseq_sym(4'b1110, 1'b1);
    drain();
    chk("unlock", 32'(locked), 32'd0);
    chk("err4", 32'(err_cnt), 32'd4);
    chk("pulse4", 32'(n_pulse), 32'd4);
    chk("bits25", 32'(bit_cnt), 32'd25);
    for (int s = 0; s < 4; s++) mseq_sym(4'b0000, 1'b1);
    drain();
    chk("relock", 32'(locked), 32'd1);
    chk("err4b", 32'(err_cnt), 32'd4);
    chk("bits32", 32'(bit_cnt), 32'd32);
    // three back-to-back strobes: third is dropped
    mseq_sym(4'b0000, 1'b0);
    mseq_sym(4'b0000, 1'b0);
    sym_bits(4'b0110, 1'b0);
    drain();
    chk("overrun", 32'(overrun), 32'd1);
    chk("ovr_lock", 32'(locked), 32'd1);
    chk("ovr_err", 32'(err_cnt), 32'd4);
    chk("bits40", 32'(bit_cnt), 32'd40);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);
    chk("clr_cnt", {err_cnt, bit_cnt}, 32'd0);
    chk("clr_lock", 32'(locked), 32'd1);
    // reset in the middle of a symbol while locked
    mseq_sym(4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_quiet", 32'(bit_valid), 32'd0);
    chk("midrst_lock", 32'(locked), 32'd0);
    chk("final_queue", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
